// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared constants and response bundle for dmem_arbiter.
// Address checking of granted accesses is built in with DMEM_ARB_ADDR_CHK_EN.
package dmem_arb_pkg;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  localparam int DMEM_WORDS   = 256;
  localparam int DMEM_IDX_LSB = 2;
  localparam int DMEM_IDX_MSB = 9;

  localparam int MAX_WAIT_DEF = 4;
  localparam int WAIT_W       = 4;

  typedef struct packed {
    logic        valid;
    logic        owner;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  // Outside the 256-word window or not word aligned.
  function automatic logic addr_illegal(input logic [31:0] a);
    return (a[31:DMEM_IDX_MSB+1] != '0) ||
           (a[DMEM_IDX_LSB-1:0] != '0);
  endfunction

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// dmem_arb_starve_ctr: counts cycles the debug port is denied and
// raises force_p1 once the count reaches MAX_WAIT.
module dmem_arb_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic p1_req,
  input  logic p1_gnt,
  output logic force_p1
);

  localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt;

  // A grant clears even when the count is saturated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (p1_gnt || !p1_req) begin
      wait_cnt <= '0;
    end else if (wait_cnt != MAX_W) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  assign force_p1 = (wait_cnt == MAX_W);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares dmem between the LSU (port 0) and debug/DMA (port 1).
// Define DMEM_ARB_ADDR_CHK_EN to block and flag illegal addresses.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p0_req,
  input  logic             p0_we,
  input  logic [31:0]      p0_addr,
  input  logic [31:0]      p0_wdata,
  input  logic             p1_req,
  input  logic             p1_we,
  input  logic [31:0]      p1_addr,
  input  logic [31:0]      p1_wdata,
  output logic             p0_gnt,
  output logic             p0_rvalid,
  output logic [31:0]      p0_rdata,
  output logic             p0_err,
  output logic             p1_gnt,
  output logic             p1_rvalid,
  output logic [31:0]      p1_rdata,
  output logic             p1_err,
  output logic             mem_read,
  output logic             mem_write,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] conflict_cnt
);

  logic        force_p1;
  logic        any_gnt;
  logic        sel_we;
  logic        illegal;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  rsp_t        rsp_d;
  rsp_t        rsp_q;

  dmem_arb_starve_ctr #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .p1_req  (p1_req),
    .p1_gnt  (p1_gnt),
    .force_p1(force_p1)
  );

  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!rst) begin
      p1_gnt = p1_req && (!p0_req || force_p1);
      p0_gnt = p0_req && !p1_gnt;
    end
  end

  assign any_gnt = p0_gnt || p1_gnt;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    unique case (1'b1)
      p0_gnt: begin
        sel_we    = p0_we;
        sel_addr  = p0_addr;
        sel_wdata = p0_wdata;
      end
      p1_gnt: begin
        sel_we    = p1_we;
        sel_addr  = p1_addr;
        sel_wdata = p1_wdata;
      end
      default: ;
    endcase
  end

`ifdef DMEM_ARB_ADDR_CHK_EN
  assign illegal = any_gnt && addr_illegal(sel_addr);
`else
  assign illegal = 1'b0;
`endif

  assign mem_read  = any_gnt && !sel_we && !illegal;
  assign mem_write = any_gnt && sel_we && !illegal;
  assign mem_addr  = sel_addr;
  assign mem_wdata = sel_wdata;

  always_comb begin
    rsp_d       = '0;
    rsp_d.valid = any_gnt;
    rsp_d.owner = p1_gnt ? PORT_DBG : PORT_CORE;
    rsp_d.err   = illegal;
    rsp_d.data  = mem_read ? mem_rdata : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_q <= '0;
    end else begin
      rsp_q <= rsp_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (p0_req && p1_req && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

  assign p0_rvalid = rsp_q.valid && (rsp_q.owner == PORT_CORE);
  assign p1_rvalid = rsp_q.valid && (rsp_q.owner == PORT_DBG);
  assign p0_rdata  = p0_rvalid ? rsp_q.data : '0;
  assign p1_rdata  = p1_rvalid ? rsp_q.data : '0;
  assign p0_err    = p0_rvalid && rsp_q.err;
  assign p1_err    = p1_rvalid && rsp_q.err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed steps plus randomized traffic against a
// transaction-level model of the arbiter and a word-array memory.
module tb_dmem_arbiter;

  localparam int MW   = 4;
  localparam int CW   = 4;
  localparam int CMAX = 15;
`ifdef DMEM_ARB_ADDR_CHK_EN
  localparam logic EXP_ILL_ERR = 1'b1;
`else
  localparam logic EXP_ILL_ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [31:0]   p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic          p0_gnt, p0_rvalid, p0_err;
  logic          p1_gnt, p1_rvalid, p1_err;
  logic [31:0]   p0_rdata, p1_rdata;
  logic          mem_read, mem_write;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic [CW-1:0] conflict_cnt;

  logic [31:0] dmem [256];
  logic [31:0] rm [256];

  int checks = 0;
  int errors = 0;
  int w = 0;
  int conf = 0;
  logic obs_g1, lg0, lg1;
  bit pend0, pend1;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .MAX_WAIT(MW),
    .CNT_W   (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .p0_req      (p0_req),
    .p0_we       (p0_we),
    .p0_addr     (p0_addr),
    .p0_wdata    (p0_wdata),
    .p1_req      (p1_req),
    .p1_we       (p1_we),
    .p1_addr     (p1_addr),
    .p1_wdata    (p1_wdata),
    .p0_gnt      (p0_gnt),
    .p0_rvalid   (p0_rvalid),
    .p0_rdata    (p0_rdata),
    .p0_err      (p0_err),
    .p1_gnt      (p1_gnt),
    .p1_rvalid   (p1_rvalid),
    .p1_rdata    (p1_rdata),
    .p1_err      (p1_err),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .conflict_cnt(conflict_cnt)
  );

  // Environment memory standing in for dmem.
  assign mem_rdata = dmem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_write) dmem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r = $urandom_range(0, 9);
    logic [31:0] a = $urandom_range(0, 15) * 4;
    if (r == 0) a = $urandom;
    else if (r == 1) a = a + 32'd1;
    return a;
  endfunction

  // One cycle: starts at posedge+1 with inputs driven, ends at posedge+1.
  task automatic cyc(input bit do_rst);
    bit g0, g1, gnt, we, ill, nv, np;
    logic [31:0] a, d, nd;
    #3;
    g0 = 0;
    g1 = 0;
    if (!rst) begin
      g1 = p1_req && (!p0_req || w == MW);
      g0 = p0_req && !g1;
    end
    gnt = g0 || g1;
    we  = g1 ? p1_we : (g0 ? p0_we : 1'b0);
    a   = g1 ? p1_addr : (g0 ? p0_addr : 32'd0);
    d   = g1 ? p1_wdata : (g0 ? p0_wdata : 32'd0);
    ill = 0;
`ifdef DMEM_ARB_ADDR_CHK_EN
    ill = gnt && (a >= 32'd1024 || a % 4 != 0);
`endif
    chk("p0_gnt", p0_gnt, g0);
    chk("p1_gnt", p1_gnt, g1);
    chk("mem_read", mem_read, gnt && !we && !ill);
    chk("mem_write", mem_write, gnt && we && !ill);
    chk("mem_addr", mem_addr, a);
    chk("mem_wdata", mem_wdata, d);
    obs_g1 = p1_gnt;
    lg0 = g0;
    lg1 = g1;
    nv = gnt;
    np = g1;
    nd = (gnt && !we && !ill) ? rm[(a / 4) % 256] : 32'd0;
    if (gnt && we && !ill) rm[(a / 4) % 256] = d;
    if (rst) begin
      w = 0;
      conf = 0;
    end else begin
      w = (p1_req && !g1) ? ((w < MW) ? w + 1 : MW) : 0;
      if (p0_req && p1_req && conf < CMAX) conf++;
    end
    @(posedge clk);
    #1;
    if (do_rst) begin
      rst = 1'b1;
      #1;
      nv = 0;
      w = 0;
      conf = 0;
      chk("rst_p0_gnt", p0_gnt, 0);
      chk("rst_mem_read", mem_read, 0);
    end
    chk("p0_rvalid", p0_rvalid, nv && !np);
    chk("p1_rvalid", p1_rvalid, nv && np);
    if (nv && !np) begin
      chk("p0_rdata", p0_rdata, nd);
      chk("p0_err", p0_err, ill);
    end
    if (nv && np) begin
      chk("p1_rdata", p1_rdata, nd);
      chk("p1_err", p1_err, ill);
    end
    chk("conflict_cnt", 32'(conflict_cnt), conf);
  endtask

  task automatic drive(input bit r0, input bit we0, input logic [31:0] a0,
                       input logic [31:0] d0, input bit r1, input bit we1,
                       input logic [31:0] a1, input logic [31:0] d1);
    p0_req = r0; p0_we = we0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = we1; p1_addr = a1; p1_wdata = d1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      dmem[i] = '0;
      rm[i] = '0;
    end
    rst = 1'b1;
    drive(1, 0, 0, 0, 1, 1, 32'h8, 32'h5);
    @(posedge clk);
    #1;
    cyc(0);
    chk("reset_p0_rdata", p0_rdata, 0);
    chk("reset_p1_err", p1_err, 0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0);

    drive(1, 1, 32'h0, 32'hDEADBEEF, 0, 0, 0, 0);
    cyc(0);
    drive(1, 0, 32'h0, 32'h0, 0, 0, 0, 0);
    cyc(0);
    chk("p0_read_deadbeef", p0_rdata, 32'hDEADBEEF);

    drive(0, 0, 0, 0, 1, 1, 32'h40, 32'h12345678);
    cyc(0);
    drive(1, 0, 32'h40, 0, 0, 0, 0, 0);
    cyc(0);
    chk("p0_sees_p1_write", p0_rdata, 32'h12345678);

    drive(0, 0, 0, 0, 1, 0, 32'h402, 0);
    cyc(0);
    chk("ill_rvalid", p1_rvalid, 1);
    chk("ill_err", p1_err, EXP_ILL_ERR);

    drive(1, 0, 32'h0, 0, 1, 0, 32'h40, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(0);
      chk("contend_p1_slot", obs_g1, (i % 5) == 4);
    end
    chk("conflict_sat", 32'(conflict_cnt), 15);

    cyc(1);
    chk("rst_drop_rvalid", p0_rvalid, 0);
    chk("rst_conflict", 32'(conflict_cnt), 0);
    cyc(0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(0);
      chk("post_rst_p1_slot", obs_g1, (i % 5) == 4);
    end
    chk("post_rst_conflict", 32'(conflict_cnt), 6);

    pend0 = 0;
    pend1 = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      if (!pend0 && $urandom_range(0, 3) != 0) begin
        pend0 = 1;
        p0_we = 1'($urandom_range(0, 1));
        p0_addr = rand_addr();
        p0_wdata = $urandom;
      end
      if (!pend1 && $urandom_range(0, 2) != 0) begin
        pend1 = 1;
        p1_we = 1'($urandom_range(0, 1));
        p1_addr = rand_addr();
        p1_wdata = $urandom;
      end
      p0_req = pend0;
      p1_req = pend1;
      cyc(0);
      if (lg0) pend0 = 0;
      if (lg1) pend1 = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
